booth_seq_ctrl: RTL and testbench

//  Iterative radix-4 Booth multiply sequencer. It accepts one signed operand pair

---
 rtl/booth_seq_ctrl.sv | 115 +++++++++++
 tb/tb_booth_seq_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// Iterative radix-4 Booth multiply sequencer: one Booth digit per clock on a shared accumulator.
// Optional macro BOOTH_EARLY_TERM_EN ends RUN once all remaining multiplier digits are zero.
module booth_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int IDX_W = (WIDTH / 2 > 2) ? $clog2(WIDTH / 2) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_nxt;
    logic signed [WIDTH-1:0]  a_reg, b_reg;
    logic signed [PW-1:0]     acc, acc_nxt, a_ext, term;
    logic [IDX_W-1:0]         idx;
    logic [WIDTH:0]           b_ext, b_sh;
    logic [2:0]               trip;
    logic                     last_digit;

    // Radix-4 recoding of one bit triple into a multiple of A (0, +-A, +-2A).
    function automatic logic signed [PW-1:0] booth_term(input logic [2:0] t,
                                                        input logic signed [PW-1:0] x);
        logic signed [PW-1:0] neg;
        neg = ~x + PW'(1);
        case (t)
            3'b001, 3'b010: booth_term = x;
            3'b011:         booth_term = x <<< 1;
            3'b100:         booth_term = neg <<< 1;
            3'b101, 3'b110: booth_term = neg;
            default:        booth_term = '0;
        endcase
    endfunction

    // b_reg[-1] is the implicit zero appended below the LSB.
    always_comb begin
        a_ext   = PW'(a_reg);
        b_ext   = {b_reg, 1'b0};
        b_sh    = b_ext >> {idx, 1'b0};
        trip    = b_sh[2:0];
        term    = booth_term(trip, a_ext);
        acc_nxt = acc + (term <<< {idx, 1'b0});
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic signed [WIDTH-1:0] b_rest;

    // Arithmetic shift fills with the sign, so a uniform remainder means no nonzero digits left.
    always_comb begin
        b_rest     = b_reg >>> {idx, 1'b1};
        last_digit = (idx == LAST) || (b_rest == '0) || (b_rest == '1);
    end
`else
    always_comb begin
        last_digit = (idx == LAST);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid)  state_nxt = RUN;
            RUN:     if (last_digit)   state_nxt = DONE;
            DONE:    if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_ready  = (state == IDLE);
        result_valid = (state == DONE);
        busy         = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            idx   <= '0;
        end else if (state == IDLE && start_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            idx   <= '0;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            if (!last_digit) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl (WIDTH=8), latency expectations follow BOOTH_EARLY_TERM_EN.
module tb_booth_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [7:0]  a, b;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] product;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    booth_seq_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] ta, input logic [7:0] tb_v, input string tag);
        a           = ta;
        b           = tb_v;
        start_valid = 1'b1;
        check(start_ready, 1, {tag, "_start_ready"});
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        a           = 8'hAA;
        b           = 8'h55;
        check(busy, 1, {tag, "_busy"});
    endtask

    task automatic wait_result(input int lat_full, input int lat_early, input string tag);
        int n;
        int lat;
`ifdef BOOTH_EARLY_TERM_EN
        lat = lat_early;
`else
        lat = lat_full;
`endif
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!result_valid && n < 20);
        check(n, lat, {tag, "_latency"});
    endtask

    task automatic finish_result(input logic [15:0] exp, input string tag);
        check(product, exp, {tag, "_product"});
        check(start_ready, 0, {tag, "_ready_in_done"});
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check(start_ready, 1, {tag, "_back_idle"});
        check(result_valid, 0, {tag, "_valid_drop"});
        check(product, exp, {tag, "_product_held"});
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp,
                          input int lat_full, input int lat_early, input string tag);
        accept(ta, tb_v, tag);
        wait_result(lat_full, lat_early, tag);
        finish_result(exp, tag);
    endtask

    initial begin
        rst_n        = 1'b0;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a            = 8'h00;
        b            = 8'h00;
        repeat (2) @(negedge clk);
        check(start_ready, 1, "rst_start_ready");
        check(result_valid, 0, "rst_result_valid");
        check(busy, 0, "rst_busy");
        check(product, 16'h0000, "rst_product");
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'd7,   8'd3,   16'h0015, 4, 2, "mul_7x3");
        run_op(8'hFB,  8'd7,   16'hFFDD, 4, 2, "mul_m5x7");
        run_op(8'h80,  8'h80,  16'h4000, 4, 4, "mul_m128xm128");
        run_op(8'h80,  8'h7F,  16'hC080, 4, 4, "mul_m128x127");
        run_op(8'd100, 8'd1,   16'h0064, 4, 1, "mul_100x1");

        // Backpressure: DONE holds while a new request waits
        accept(8'd12, 8'd10, "bp");
        wait_result(4, 3, "bp");
        start_valid = 1'b1;
        a           = 8'd3;
        b           = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check(product, 16'h0078, "bp_product_stable");
            check(start_ready, 0, "bp_start_ready_low");
            check(result_valid, 1, "bp_valid_held");
        end
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check(start_ready, 1, "bp_idle_after_hs");
        check(busy, 0, "bp_not_busy_after_hs");
        check(product, 16'h0078, "bp_product_in_idle");
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        check(busy, 1, "bp_second_accept");
        wait_result(4, 2, "bp2");
        finish_result(16'h000F, "bp2");

        // Asynchronous reset in the middle of RUN
        accept(8'd9, 8'h55, "arst");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check(start_ready, 1, "arst_start_ready");
        check(result_valid, 0, "arst_result_valid");
        check(busy, 0, "arst_busy");
        check(product, 16'h0000, "arst_product");
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd6, 8'd6, 16'h0024, 4, 2, "mul_6x6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
